// File: rtl/inst_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the PC, issues one fetch at a time, loads IF/ID.
// Optional FETCH_PERF_EN adds perf_fetched/perf_stall event counters.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        fetch_err
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_ERR   = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        if_valid_q, if_valid_d;
  logic        fetch_err_q, fetch_err_d;
  logic        redir_pend_q, redir_pend_d;
  logic [31:0] redir_tgt_q, redir_tgt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        req_en_q, req_en_d;
  logic        load;
  logic [7:0]  wait_inc;

  // req_en_q keeps the request low for the cycle right after reset
  assign mem_req   = req_en_q && (state_q == S_FETCH);
  assign mem_addr  = pc_q;
  assign if_pc     = if_pc_q;
  assign if_inst   = if_inst_q;
  assign if_valid  = if_valid_q;
  assign fetch_err = fetch_err_q;
  assign wait_inc  = wait_cnt_q + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      if_pc_q      <= 32'd0;
      if_inst_q    <= 32'd0;
      if_valid_q   <= 1'b0;
      fetch_err_q  <= 1'b0;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= 32'd0;
      wait_cnt_q   <= 8'd0;
      inst_buf_q   <= 32'd0;
      req_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      if_pc_q      <= if_pc_d;
      if_inst_q    <= if_inst_d;
      if_valid_q   <= if_valid_d;
      fetch_err_q  <= fetch_err_d;
      redir_pend_q <= redir_pend_d;
      redir_tgt_q  <= redir_tgt_d;
      wait_cnt_q   <= wait_cnt_d;
      inst_buf_q   <= inst_buf_d;
      req_en_q     <= req_en_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    if_pc_d      = if_pc_q;
    if_inst_d    = if_inst_q;
    if_valid_d   = if_valid_q;
    fetch_err_d  = fetch_err_q;
    redir_pend_d = redir_pend_q;
    redir_tgt_d  = redir_tgt_q;
    wait_cnt_d   = wait_cnt_q;
    inst_buf_d   = inst_buf_q;
    req_en_d     = 1'b1;
    load         = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (!req_en_q) begin
          if (branch_taken) begin
            pc_d       = branch_addr;
            if_valid_d = 1'b0;
          end
        end else if (mem_ready) begin
          wait_cnt_d = 8'd0;
          // A same-cycle branch is newer than any pending redirect target
          if (branch_taken || redir_pend_q) begin
            pc_d         = branch_taken ? branch_addr : redir_tgt_q;
            if_valid_d   = 1'b0;
            redir_pend_d = 1'b0;
          end else if (freeze) begin
            inst_buf_d = mem_rdata;
            state_d    = S_HOLD;
          end else begin
            if_inst_d  = mem_rdata;
            if_pc_d    = pc_q + 32'd4;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 32'd4;
            load       = 1'b1;
          end
        end else begin
          if (branch_taken) begin
            redir_pend_d = 1'b1;
            redir_tgt_d  = branch_addr;
            if_valid_d   = 1'b0;
          end else if (!freeze) begin
            if_valid_d = 1'b0;
          end
          wait_cnt_d = wait_inc;
          if (wait_inc == TIMEOUT_CNT) begin
            fetch_err_d = 1'b1;
            state_d     = S_ERR;
          end
        end
      end

      S_HOLD: begin
        if (branch_taken) begin
          pc_d       = branch_addr;
          if_valid_d = 1'b0;
          state_d    = S_FETCH;
        end else if (!freeze) begin
          if_inst_d  = inst_buf_q;
          if_pc_d    = pc_q + 32'd4;
          if_valid_d = 1'b1;
          pc_d       = pc_q + 32'd4;
          load       = 1'b1;
          state_d    = S_FETCH;
        end
      end

      S_ERR: begin
        if (branch_taken) begin
          if_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stall_d   = perf_stall_q;
    if (load) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end
    if ((mem_req && !mem_ready) || (state_q == S_HOLD)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= 32'd0;
      perf_stall_q   <= 32'd0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end
`endif

endmodule
